avalon_slave_mem: RTL
=====================

AVALON_SLAVE_MEM -- requirements
Module: avalon_slave_mem

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning number of WAIT-state cycles inserted per access (legal range 0..15).
REQ-002 Clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Resetn  input  1  reset, asynchronous and active-low.
REQ-004 avalon_address  input  32  byte address from the master; only bits [6:2] are decoded.
REQ-005 avalon_writedata  input  32  write data.
REQ-006 avalon_byteenable  input  4  per-byte write enable; bit n enables byte [8n+7:8n].
REQ-007 avalon_read  input  1  read request.
REQ-008 avalon_write  input  1  write request.
REQ-009 avalon_readdata  output  32  registered read data; valid in the ACK cycle.
REQ-010 avalon_wait_request  output  1  stall to the master.

Function
REQ-011 The FSM SHALL have three states:
- IDLE
- WAIT
- ACK
REQ-012 IDLE, with read or write high: the block SHALL latch address[6:2], writedata, byteenable and op (write if avalon_write, else read).
- Next state is WAIT if WAIT_CYCLES>0, else ACK.
REQ-013 WAIT SHALL count WAIT_CYCLES cycles and then go to ACK.
- Changes to the master inputs during WAIT are ignored.
REQ-014 ACK SHALL last exactly one cycle and then always return to IDLE.
REQ-015 avalon_wait_request SHALL equal (avalon_read|avalon_write) && state!=ACK in IDLE and ACK, and SHALL be 1 throughout WAIT.
- Total held-request length is 2+WAIT_CYCLES cycles.
REQ-016 Address decode when latched address bit 6 = 0: the access targets memory word [5:2], 16 words x 32 bits.
REQ-017 Address decode when latched address bit 6 = 1: the access targets the STATUS register.
- Bits [31:7] are ignored, so addresses alias every 128 bytes.
REQ-018 A memory write SHALL commit on the clock edge ending the ACK cycle.
- Only the enabled bytes are updated.
- byteenable=0000 writes nothing but still completes.
REQ-019 A memory read SHALL load avalon_readdata with the addressed word on the edge entering ACK.
- avalon_readdata holds its value until the next read completes.
REQ-020 A STATUS read SHALL return {access_count[15:0], 15'b0, err}.
REQ-021 A STATUS write SHALL clear access_count and err at the end of ACK, regardless of byteenable.
REQ-022 access_count SHALL increment by 1 at each completed memory access (ACK of a non-STATUS access).
- It wraps 0xFFFF->0x0000.
REQ-023 read and write high together in IDLE: the access SHALL be treated as a write.
- err SHALL be set (sticky).
- If the same access is a STATUS write, the clear wins.
REQ-024 Request dropped by the master during WAIT (protocol violation): the block SHALL still traverse ACK.
- A latched write still commits.
- No extra stall is generated.
REQ-025 Back-to-back requests: a request held high after ACK SHALL be accepted as a new access in the following IDLE cycle.
- Minimum spacing is one IDLE cycle between ACKs.

Reset
REQ-026 Resetn low SHALL asynchronously force all of the following:
- state=IDLE and wait counter=0
- all 16 memory words=0
- access_count=0 and err=0
- avalon_readdata=0
REQ-027 While Resetn is low, avalon_wait_request SHALL be 1 if read|write is high, else 0.
REQ-028 Reset mid-access SHALL abandon the access with no memory update and no count.
- After release the block behaves as if the master had just asserted its request in IDLE.

Structure
REQ-029 Package avalon_slave_pkg SHALL hold:
- the state encoding (IDLE, WAIT, ACK)
- STATUS_SEL_BIT=6
- MEM_WORDS=16
- the status-field bit positions
REQ-030 The memory array with byte-enable write SHALL be sub-module avalon_slave_regfile.
- One write port, one asynchronous read port, asynchronous clear.
- The FSM, counters and decode stay in avalon_slave_mem.

Verification
REQ-031 Reset release, WAIT_CYCLES=2, write 0xDEADBEEF to 0x04 with be=1111 -> wait_request high 3 cycles, low 1 cycle; subsequent read of 0x04 returns 0xDEADBEEF.
REQ-032 Write 0x11223344 to 0x08 with be=0101 over a word holding 0xAABBCCDD -> read returns 0xAA22CC44.
REQ-033 WAIT_CYCLES=0, write to 0x00 then read 0x00 held back-to-back -> each access stalls exactly 1 cycle, ACKs separated by one IDLE cycle.
REQ-034 Three memory accesses, then read 0x40 -> 0x00030000; assert read+write together to 0x0C -> write commits and the next STATUS read shows err=1; write 0x40 -> next STATUS read = 0x00000000.
REQ-035 Assert Resetn low during WAIT of a write to 0x10 -> word 0x10 stays 0, count stays 0, FSM in IDLE after release.
REQ-036 Read 0x84 after writing 0x04 -> aliased data returned; 65536 memory accesses -> access_count wraps to 0.

Source files
------------

// File: rtl/avalon_slave_pkg.sv
// Shared encodings for the Avalon slave memory: FSM states, decode bits, STATUS layout.
// Pure declarations; no latency or backpressure of its own.
package avalon_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int STATUS_SEL_BIT = 6;
  localparam int MEM_WORDS      = 16;
  localparam int WORD_AW        = 4;
  // Latched address covers byte-address bits [6:2]; its MSB selects STATUS.
  localparam int LAT_AW         = STATUS_SEL_BIT - 1;

  localparam int STATUS_ERR_BIT = 0;
  localparam int STATUS_CNT_LSB = 16;
  localparam int STATUS_CNT_W   = 16;

  function automatic logic [31:0] status_word(input logic [STATUS_CNT_W-1:0] cnt,
                                              input logic err);
    logic [31:0] w;
    w = '0;
    w[STATUS_CNT_LSB +: STATUS_CNT_W] = cnt;
    w[STATUS_ERR_BIT] = err;
    return w;
  endfunction

endpackage

// File: rtl/avalon_slave_regfile.sv
// 16x32 word store with per-byte write enables; async read, write on rising edge.
// Zero-latency read; never stalls (writes accepted whenever wr_vld is high).
module avalon_slave_regfile
  import avalon_slave_pkg::*;
(
  input  logic               core_clk,
  input  logic               arst_n,
  input  logic               wr_vld,
  input  logic [WORD_AW-1:0] wr_addr,
  input  logic [31:0]        wr_dat,
  input  logic [3:0]         wr_be,
  input  logic [WORD_AW-1:0] rd_addr,
  output logic [31:0]        rd_dat
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_vld) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_dat[8*b +: 8];
        end
      end
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/avalon_slave_mem.sv
// Avalon-MM slave: 16-word memory plus STATUS register behind an IDLE/WAIT/ACK FSM.
// Latency 2+WAIT_CYCLES cycles per access; wait_request stalls the master until ACK.
module avalon_slave_mem
  import avalon_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [31:0] avalon_address,
  input  logic [31:0] avalon_writedata,
  input  logic [3:0]  avalon_byteenable,
  input  logic        avalon_read,
  input  logic        avalon_write,
  output logic [31:0] avalon_readdata,
  output logic        avalon_wait_request
);

  localparam int         SEL       = LAT_AW - 1;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                    state_q, state_d;
  logic [3:0]                wcnt_q, wcnt_d;
  logic                      accept;
  logic                      req;

  logic [LAT_AW-1:0]         lat_addr_q;
  logic [31:0]               lat_wdata_q;
  logic [3:0]                lat_be_q;
  logic                      lat_wr_q;
  logic                      lat_both_q;

  logic [STATUS_CNT_W-1:0]   access_count;
  logic                      err;

  logic [LAT_AW-1:0]         acc_addr;
  logic                      acc_wr;
  logic [31:0]               rf_rdata;
  logic                      rf_we;
  logic                      unused_addr;

  assign req         = avalon_read | avalon_write;
  assign unused_addr = ^{avalon_address[31:STATUS_SEL_BIT+1], avalon_address[1:0]};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    wcnt_d              = wcnt_q;
    accept              = 1'b0;
    avalon_wait_request = 1'b0;
    case (state_q)
      IDLE: begin
        avalon_wait_request = req;
        if (req) begin
          accept  = 1'b1;
          wcnt_d  = '0;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        avalon_wait_request = 1'b1;
        if (wcnt_q == WAIT_LAST) begin
          state_d = ACK;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Master inputs are only sampled on acceptance; WAIT ignores them entirely.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      lat_wr_q    <= 1'b0;
      lat_both_q  <= 1'b0;
    end else if (accept) begin
      lat_addr_q  <= avalon_address[STATUS_SEL_BIT:2];
      lat_wdata_q <= avalon_writedata;
      lat_be_q    <= avalon_byteenable;
      lat_wr_q    <= avalon_write;
      lat_both_q  <= avalon_read & avalon_write;
    end
  end

  // With WAIT_CYCLES=0 the edge entering ACK is the accept edge, so take the live inputs then.
  assign acc_addr = (state_q == IDLE) ? avalon_address[STATUS_SEL_BIT:2] : lat_addr_q;
  assign acc_wr   = (state_q == IDLE) ? avalon_write : lat_wr_q;
  assign rf_we    = (state_q == ACK) && lat_wr_q && !lat_addr_q[SEL];

  avalon_slave_regfile u_regfile (
    .core_clk (Clock),
    .arst_n   (Resetn),
    .wr_vld   (rf_we),
    .wr_addr  (lat_addr_q[WORD_AW-1:0]),
    .wr_dat   (lat_wdata_q),
    .wr_be    (lat_be_q),
    .rd_addr  (acc_addr[WORD_AW-1:0]),
    .rd_dat   (rf_rdata)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      avalon_readdata <= '0;
    end else if (state_d == ACK && !acc_wr) begin
      avalon_readdata <= acc_addr[SEL] ? status_word(access_count, err) : rf_rdata;
    end
  end

  // A STATUS write clears everything, which also beats a read+write error on that access.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      access_count <= '0;
      err          <= 1'b0;
    end else if (state_q == ACK) begin
      if (lat_addr_q[SEL]) begin
        if (lat_wr_q) begin
          access_count <= '0;
          err          <= 1'b0;
        end
      end else begin
        access_count <= access_count + 16'd1;
        if (lat_both_q) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
